// File: rtl/lapido_pkg.sv
// rtl/lapido_pkg.sv - shared Lapido extension modes and default widths
package lapido_pkg;

   localparam logic [1:0] EXT_ZERO   = 2'b00;
   localparam logic [1:0] EXT_SIGN   = 2'b01;
   localparam logic [1:0] EXT_UPPER  = 2'b10;
   localparam logic [1:0] EXT_BRANCH = 2'b11;

   localparam int DEF_IN_W  = 16;
   localparam int DEF_OUT_W = 32;
   localparam int DEF_TAG_W = 5;

endpackage

// File: rtl/imm_extend_core.sv
// rtl/imm_extend_core.sv - combinational immediate extension for one transaction
module imm_extend_core
   import lapido_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] data,
   output logic             neg
);

   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] upper;

   assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
   assign sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
   assign upper = {imm, {(OUT_W-IN_W){1'b0}}};

   always_comb begin
      data = zext;
      case (mode)
         EXT_ZERO:   data = zext;
         EXT_SIGN:   data = sext;
         EXT_UPPER:  data = upper;
         // sign is fixed before the shift; the two bits leaving the MSB are dropped
         EXT_BRANCH: data = sext << 2;
         default:    data = zext;
      endcase
   end

   assign neg = data[OUT_W-1];

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extender with a 2-entry skid buffer
module imm_extend_pipe
   import lapido_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg
);

   logic [OUT_W-1:0] ext_data;
   logic             ext_neg;

   logic             skid_valid;
   logic [OUT_W-1:0] skid_data;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_neg;

   logic accept;
   logic deliver;
   logic load_main_skid;
   logic load_main_in;
   logic load_skid;
   logic out_valid_nx;
   logic skid_valid_nx;

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .data (ext_data),
      .neg  (ext_neg)
   );

   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   always_comb begin
      load_main_skid = 1'b0;
      load_main_in   = 1'b0;
      load_skid      = 1'b0;
      out_valid_nx   = out_valid;
      skid_valid_nx  = skid_valid;
      if (!out_valid || deliver) begin
         // skid holds the older transaction, so it always drains first
         if (skid_valid) begin
            load_main_skid = 1'b1;
            out_valid_nx   = 1'b1;
            skid_valid_nx  = 1'b0;
         end else if (accept) begin
            load_main_in = 1'b1;
            out_valid_nx = 1'b1;
         end else begin
            out_valid_nx = 1'b0;
         end
      end else if (accept) begin
         load_skid     = 1'b1;
         skid_valid_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tag    <= '0;
         out_neg    <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_tag   <= '0;
         skid_neg   <= 1'b0;
      end else begin
         in_ready   <= ~skid_valid_nx;
         out_valid  <= out_valid_nx;
         skid_valid <= skid_valid_nx;
         if (load_main_skid) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
            out_neg  <= skid_neg;
         end else if (load_main_in) begin
            out_data <= ext_data;
            out_tag  <= in_tag;
            out_neg  <= ext_neg;
         end
         if (load_skid) begin
            skid_data <= ext_data;
            skid_tag  <= in_tag;
            skid_neg  <= ext_neg;
         end
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed vector bench for imm_extend_pipe
module tb_imm_extend_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        out_neg;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] imm;
      logic [4:0]  tag;
      logic [31:0] data;
      logic        neg;
   } vec_t;

   vec_t vecs[10];

   imm_extend_pipe #(
      .IN_W  (16),
      .OUT_W (32),
      .TAG_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_neg   (out_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && in_valid)
         assert (!$isunknown(in_mode)) else $error("in_mode unknown while in_valid");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag);
      in_valid = v;
      in_mode  = m;
      in_imm   = imm;
      in_tag   = tag;
   endtask

   initial begin
      vecs[0] = '{2'b01, 16'h8001, 5'd3,  32'hFFFF8001, 1'b1};
      vecs[1] = '{2'b00, 16'h8001, 5'd4,  32'h00008001, 1'b0};
      vecs[2] = '{2'b10, 16'h1234, 5'd5,  32'h12340000, 1'b0};
      vecs[3] = '{2'b11, 16'hFFFF, 5'd6,  32'hFFFFFFFC, 1'b1};
      vecs[4] = '{2'b11, 16'h0010, 5'd7,  32'h00000040, 1'b0};
      vecs[5] = '{2'b01, 16'h7FFF, 5'd8,  32'h00007FFF, 1'b0};
      vecs[6] = '{2'b10, 16'h8000, 5'd9,  32'h80000000, 1'b1};
      vecs[7] = '{2'b11, 16'h8000, 5'd10, 32'hFFFE0000, 1'b1};
      vecs[8] = '{2'b11, 16'h4000, 5'd11, 32'h00010000, 1'b0};
      vecs[9] = '{2'b00, 16'hFFFF, 5'd31, 32'h0000FFFF, 1'b0};

      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 2'b00, 16'h0, 5'd0);

      #2;
      chk("reset in_ready",  32'(in_ready),  32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data",  out_data,       32'd0);
      chk("reset out_tag",   32'(out_tag),   32'd0);
      chk("reset out_neg",   32'(out_neg),   32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready before first edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("in_ready after first edge", 32'(in_ready), 32'd1);

      // table vectors, streamed back to back with out_ready=1
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].tag);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d data", i),  out_data,       vecs[i].data);
         chk($sformatf("vec%0d tag", i),   32'(out_tag),   32'(vecs[i].tag));
         chk($sformatf("vec%0d neg", i),   32'(out_neg),   32'(vecs[i].neg));
         chk($sformatf("vec%0d ready", i), 32'(in_ready),  32'd1);
      end
      drive(1'b0, 2'b00, 16'h0, 5'd0);
      @(negedge clk);
      chk("drain out_valid", 32'(out_valid), 32'd0);

      // back-pressure: two entries held, third not accepted
      out_ready = 1'b0;
      drive(1'b1, 2'b01, 16'hFFF0, 5'd1);
      @(negedge clk);
      chk("bp t1 valid", 32'(out_valid), 32'd1);
      chk("bp t1 tag",   32'(out_tag),   32'd1);
      chk("bp t1 ready", 32'(in_ready),  32'd1);
      drive(1'b1, 2'b00, 16'h0022, 5'd2);
      @(negedge clk);
      chk("bp t2 ready", 32'(in_ready), 32'd0);
      chk("bp t2 tag",   32'(out_tag),  32'd1);
      drive(1'b0, 2'b00, 16'h0, 5'd0);
      @(negedge clk);
      chk("bp hold tag",  32'(out_tag),  32'd1);
      chk("bp hold data", out_data,      32'hFFFFFFF0);
      chk("bp hold neg",  32'(out_neg),  32'd1);
      chk("bp hold ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp drain t2 valid", 32'(out_valid), 32'd1);
      chk("bp drain t2 tag",   32'(out_tag),   32'd2);
      chk("bp drain t2 data",  out_data,       32'h00000022);
      chk("bp drain ready",    32'(in_ready),  32'd1);
      @(negedge clk);
      chk("bp empty", 32'(out_valid), 32'd0);

      // streaming: 8 outputs on 8 consecutive cycles
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'b00, 16'(i * 3), 5'(i));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stream%0d tag", i),   32'(out_tag),   32'(i));
         chk($sformatf("stream%0d data", i),  out_data,       32'(i * 3));
      end
      drive(1'b0, 2'b00, 16'h0, 5'd0);
      @(negedge clk);
      chk("stream end valid", 32'(out_valid), 32'd0);

      // async reset while two entries are held
      out_ready = 1'b0;
      drive(1'b1, 2'b01, 16'h9000, 5'd12);
      @(negedge clk);
      drive(1'b1, 2'b00, 16'h0033, 5'd13);
      @(negedge clk);
      drive(1'b0, 2'b00, 16'h0, 5'd0);
      chk("pre-reset full", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid reset valid", 32'(out_valid), 32'd0);
      chk("mid reset data",  out_data,       32'd0);
      chk("mid reset ready", 32'(in_ready),  32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post reset idle%0d", i), 32'(out_valid), 32'd0);
      end
      drive(1'b1, 2'b10, 16'hABCD, 5'd20);
      @(negedge clk);
      drive(1'b0, 2'b00, 16'h0, 5'd0);
      chk("post reset new valid", 32'(out_valid), 32'd1);
      chk("post reset new data",  out_data,       32'hABCD0000);
      chk("post reset new tag",   32'(out_tag),   32'd20);
      @(negedge clk);
      chk("post reset drained", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the Lapido datapath; successor to the combinational zero-only extender.
- Sits between instruction decode and the ALU operand mux.
- Supports four extension modes selected per transaction: zero, sign, upper-load, branch-offset.
- Carries a tag alongside each immediate; valid/ready on both sides with a 2-entry skid buffer, so back-pressure never drops data.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; legal only if OUT_W >= IN_W+2.
- TAG_W, 5, width of the sideband tag (destination register index), passed through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a transaction.
- in_ready  output  1  block can accept; registered, equals NOT skid_valid.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode, encoded as in the Behaviour section.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_data/out_tag hold a transaction.
- out_ready  input  1  consumer accepts.
- out_data  output  OUT_W  extended result.
- out_tag  output  TAG_W  tag of the transaction on out_data.
- out_neg  output  1  1 when result MSB is 1; registered with out_data.

Behaviour:
- Modes:
  - 00 ZERO: upper OUT_W-IN_W bits = 0, low bits = imm.
  - 01 SIGN: upper bits replicate imm[IN_W-1].
  - 10 UPPER: result = imm placed in bits [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - 11 BRANCH: sign-extend imm to OUT_W, then shift left 2. Bits shifted out of the MSB are discarded; sign comes from imm[IN_W-1] before the shift.
- Extension logic is combinational on the input side. The result is registered, so latency is exactly 1 cycle from accept to out_valid when the output is empty or draining.
- Accept and deliver events:
  - accept = in_valid & in_ready.
  - deliver = out_valid & out_ready.
- Storage: main register (out_*) plus one skid register (skid_valid, skid_data, skid_tag, skid_neg).
- Update rules per cycle:
  - main empty or deliver: main loads from skid if skid_valid, else from accept if accept. skid_valid clears when skid is moved.
  - main full and no deliver: accept writes the skid register and sets skid_valid.
  - Never accept when skid_valid=1 (in_ready=0).
- Simultaneous accept+deliver with skid empty: main reloads from the new input; throughput is 1 per cycle.
- Simultaneous accept+deliver with skid full: impossible, since in_ready=0.
- Order is strictly FIFO, with at most 2 transactions in flight.
- Reset (rst_n=0, async):
  - out_valid=0, skid_valid=0, in_ready=0 while asserted.
  - out_data=0, out_tag=0, out_neg=0.
  - in_ready goes 1 on the first clock edge after rst_n deasserts.
- Reset mid-transfer discards both entries; no partial output.
- Unknown/X in_mode while in_valid=1 is illegal; the bench asserts this.
- out_* are stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package lapido_pkg:
  - mode localparams EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11.
  - default widths IN_W/OUT_W/TAG_W.
- Sub-module imm_extend_core: purely combinational (imm, mode) -> (data, neg), parametrised IN_W/OUT_W.
- Top-level holds the skid-buffer control and registers.

Test Plan:
- Reset then SIGN in_imm=16'h8001, out_ready=1 -> next cycle out_data=32'hFFFF8001, out_neg=1, tag echoed.
- ZERO 16'h8001 -> 32'h00008001, out_neg=0.
- UPPER 16'h1234 -> 32'h12340000.
- BRANCH 16'hFFFF -> 32'hFFFFFFFC.
- BRANCH 16'h0010 -> 32'h00000040.
- Back-pressure: out_ready=0, send tags 1,2 back-to-back -> in_ready drops after tag 2, out_tag=1 held stable. Raise out_ready -> tags 1 then 2 on consecutive cycles, in_ready returns 1.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with tags 0..7 -> 8 outputs on 8 consecutive cycles, in order, no bubbles.
- Async reset asserted mid-cycle with 2 entries held -> out_valid=0 and out_data=0 immediately, no outputs after release until new input.
